// File: rtl/matrix_8x8_scan.sv
// matrix_8x8_scan: 8x8 key-matrix scanner with whole-frame debounce and press/release events.
// Define MATRIX_SCAN_SYNC_EN to pass rows through a two-flop synchronizer before sampling.
module matrix_8x8_scan #(
    parameter int SCAN_DIV = 16,
    parameter int SETTLE   = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        E,
    input  logic [7:0]  rows,
    output logic [7:0]  columns,
    output logic [63:0] state,
    output logic        frame_done,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [5:0]  ev_key,
    output logic        ev_press
);
    localparam int SW = $clog2(SCAN_DIV);
    typedef enum logic {IDLE, PRESENT} fsm_t;
    fsm_t        fsm_q, fsm_d;
    logic [SW-1:0] step_q, step_d;
    logic [2:0]  col_q, col_d;
    logic        run_q;
    logic [7:0]  columns_q, columns_d;
    logic [63:0] raw_q, raw_d, prev_q, prev_d, state_q, state_d, diff_q, diff_d, frame;
    logic [3:0]  match_q, match_d;
    logic        frame_done_q, frame_done_d, ev_press_q, ev_press_d, tick, smp, accept;
    logic [5:0]  ev_key_q, ev_key_d;
    logic [7:0]  rows_s;
    logic [2:0]  smp_col;

    function automatic logic [5:0] lowest(input logic [63:0] v);
        lowest = '0;
        for (int i = 63; i >= 0; i--)
            if (v[i]) lowest = 6'(i);
    endfunction

    assign tick = E & run_q & (step_q == SW'(SETTLE));
`ifdef MATRIX_SCAN_SYNC_EN
    // The sample strobe and its column ride a pipeline matching the synchronizer depth.
    logic [7:0] sync1_q, sync2_q;
    logic [1:0] stb_q;
    logic [5:0] colp_q;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= 8'hFF;
            sync2_q <= 8'hFF;
            stb_q   <= '0;
            colp_q  <= '0;
        end else begin
            sync1_q <= rows;
            sync2_q <= sync1_q;
            stb_q   <= E ? {stb_q[0], tick} : 2'b00;
            colp_q  <= {colp_q[2:0], col_q};
        end
    end
    assign rows_s  = sync2_q;
    assign smp     = E & stb_q[1];
    assign smp_col = colp_q[5:3];
`else
    assign rows_s  = rows;
    assign smp     = tick;
    assign smp_col = col_q;
`endif

    always_comb begin
        step_d = step_q;
        col_d  = col_q;
        if (!E) begin
            step_d = '0;
            col_d  = '0;
        end else if (run_q) begin
            step_d = (step_q == SW'(SCAN_DIV - 1)) ? '0 : step_q + 1'b1;
            col_d  = (step_q == SW'(SCAN_DIV - 1)) ? col_q + 3'd1 : col_q;
        end
        columns_d = E ? ~(8'b1 << col_d) : 8'hFF;
        frame = raw_q;
        frame[{smp_col, 3'b000} +: 8] = ~rows_s;
        raw_d        = !E ? '0 : smp ? frame : raw_q;
        frame_done_d = smp && smp_col == 3'd7;
        prev_d       = frame_done_d ? frame : prev_q;
        match_d      = !E ? '0 : !frame_done_d ? match_q : frame != prev_q ? 4'd1 :
                       match_q == 4'(DEBOUNCE) ? match_q : match_q + 4'd1;
        accept = frame_done_q && match_q == 4'(DEBOUNCE) && raw_q != state_q && fsm_q == IDLE;
        fsm_d      = fsm_q;
        state_d    = state_q;
        diff_d     = diff_q;
        ev_key_d   = ev_key_q;
        ev_press_d = ev_press_q;
        if (accept) begin
            state_d = raw_q;
            diff_d  = raw_q ^ state_q;
            fsm_d   = PRESENT;
        end else if (fsm_q == PRESENT && ev_ready) begin
            diff_d = diff_q & ~(64'd1 << ev_key_q);
            fsm_d  = diff_d == '0 ? IDLE : PRESENT;
        end
        if (fsm_d == PRESENT) begin
            ev_key_d   = lowest(diff_d);
            ev_press_d = state_d[ev_key_d];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fsm_q        <= IDLE;
            step_q       <= '0;
            col_q        <= '0;
            run_q        <= 1'b0;
            columns_q    <= 8'hFF;
            raw_q        <= '0;
            prev_q       <= '0;
            state_q      <= '0;
            diff_q       <= '0;
            match_q      <= '0;
            frame_done_q <= 1'b0;
            ev_key_q     <= '0;
            ev_press_q   <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            step_q       <= step_d;
            col_q        <= col_d;
            run_q        <= E;
            columns_q    <= columns_d;
            raw_q        <= raw_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            diff_q       <= diff_d;
            match_q      <= match_d;
            frame_done_q <= frame_done_d;
            ev_key_q     <= ev_key_d;
            ev_press_q   <= ev_press_d;
        end
    end

    assign columns    = columns_q;
    assign state      = state_q;
    assign frame_done = frame_done_q;
    assign ev_valid   = fsm_q == PRESENT;
    assign ev_key     = ev_key_q;
    assign ev_press   = ev_press_q;
endmodule

// File: tb/tb_matrix_8x8_scan.sv
// tb_matrix_8x8_scan: frame-level key-map model of the scanner; keys change only at frame boundaries.
module tb_matrix_8x8_scan;
    logic        CLK = 1'b0, RESET = 1'b1, E = 1'b0, ev_ready;
    logic [7:0]  rows, columns;
    logic [63:0] state;
    logic        frame_done, ev_valid, ev_press;
    logic [5:0]  ev_key;

    matrix_8x8_scan #(.SCAN_DIV(4), .SETTLE(2), .DEBOUNCE(3)) dut (
        .CLK(CLK), .RESET(RESET), .E(E), .rows(rows), .columns(columns), .state(state),
        .frame_done(frame_done), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_key(ev_key),
        .ev_press(ev_press)
    );

    always #5 CLK = ~CLK;

    typedef struct {int cyc; logic [5:0] key; logic press;} hs_t;
    int          nvec = 0, nerr = 0, cyc = 0, ecnt = 0, lat = -1, mmatch = 0;
    logic        mon_on = 1'b0, rdy_rand = 1'b0, rdy_val = 1'b1, had;
    logic [7:0]  ecol;
    logic [63:0] keys_q = '0, keys_next = '0, mstate = '0, mprev = '0;
    logic [63:0] k3 = 64'h8000_0000_0000_0201;
    logic [6:0]  pend[$];
    hs_t         hs_log[$];

    // Physical matrix: the driven (low) column pulls rows low for its pressed keys.
    always_comb begin
        rows = 8'hFF;
        for (int c = 0; c < 8; c++)
            if (!columns[c]) rows = rows & ~keys_q[c*8 +: 8];
    end

    initial begin
        ev_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            ev_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        cyc++;
        if (mon_on) begin
            ecol = (ecnt == 0) ? 8'hFF : ~(8'b1 << (((ecnt - 1) / 4) % 8));
            chk("columns", columns, ecol);
            chk("state", state, mstate);
            had = pend.size() != 0;
            chk("ev_valid", ev_valid, had);
            if (had) begin
                chk("ev_key", ev_key, pend[0][5:0]);
                chk("ev_press", ev_press, pend[0][6]);
            end
            if (lat < 0) begin
                if (frame_done) begin
                    chk("first_frame", (ecnt == 32 || ecnt == 34), 1'b1);
                    lat = ecnt % 32;
                end
            end else
                chk("frame_done", frame_done, ecnt >= 32 && ecnt % 32 == lat);
            if (frame_done) begin
                mmatch = (keys_q == mprev) ? ((mmatch == 3) ? 3 : mmatch + 1) : 1;
                mprev = keys_q;
                if (mmatch == 3 && keys_q != mstate && !had) begin
                    for (int i = 0; i < 64; i++)
                        if (keys_q[i] != mstate[i]) pend.push_back({keys_q[i], 6'(i)});
                    mstate = keys_q;
                end
                keys_q = keys_next;
            end
            if (had && ev_ready) begin
                hs_log.push_back('{cyc, pend[0][5:0], pend[0][6]});
                void'(pend.pop_front());
            end
            ecnt = E ? ecnt + 1 : 0;
            if (!E) mmatch = 0;
        end
    end

    task automatic wait_frames(input int n);
        int seen = 0, t = 0;
        while (seen < n && t < n * 40 + 80) begin
            @(negedge CLK);
            if (frame_done) seen++;
            t++;
        end
        chk("frame_wait", seen, n);
        #1;
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!ev_valid && t < 400) begin
            @(negedge CLK);
            t++;
        end
        chk("valid_wait", ev_valid, 1'b1);
        #1;
    endtask

    task automatic at_edge();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_columns", columns, 8'hFF);
        chk("rst_state", state, 0);
        chk("rst_valid", ev_valid, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_key", ev_key, 0);
        chk("rst_press", ev_press, 0);
        RESET = 1'b0;
        E = 1'b1;
        mon_on = 1'b1;
        wait_frames(4);
        chk("t1_state", state, 0);
        chk("t1_events", hs_log.size(), 0);
        keys_next = 64'd1 << 21;
        wait_frames(5);
        chk("t2_state", state, 64'd1 << 21);
        chk("t2_count", hs_log.size(), 1);
        chk("t2_key", hs_log[0].key, 21);
        chk("t2_press", hs_log[0].press, 1);
        keys_next = '0;
        wait_frames(5);
        chk("t2_rel_state", state, 0);
        chk("t2_rel_count", hs_log.size(), 2);
        chk("t2_rel_key", hs_log[1].key, 21);
        chk("t2_rel_press", hs_log[1].press, 0);
        hs_log.delete();
        keys_next = k3;
        wait_frames(5);
        chk("t3_state", state, k3);
        chk("t3_count", hs_log.size(), 3);
        chk("t3_k0", hs_log[0].key, 0);
        chk("t3_k1", hs_log[1].key, 9);
        chk("t3_k2", hs_log[2].key, 63);
        chk("t3_consec", hs_log[2].cyc - hs_log[0].cyc, 2);
        keys_next = '0;
        wait_frames(5);
        hs_log.delete();
        at_edge();
        rdy_val = 1'b0;
        keys_next = k3;
        wait_valid();
        for (int i = 0; i < 3; i++) begin
            keys_next = (i % 2 == 0) ? (k3 ^ (64'd1 << 9)) : k3;
            wait_frames(1);
        end
        repeat (10) at_edge();
        chk("t4_key_held", ev_key, 0);
        chk("t4_valid_held", ev_valid, 1);
        chk("t4_no_drain", hs_log.size(), 0);
        keys_next = k3;
        at_edge();
        rdy_val = 1'b1;
        wait_frames(6);
        chk("t4_count", hs_log.size(), 3);
        chk("t4_k0", hs_log[0].key, 0);
        chk("t4_k1", hs_log[1].key, 9);
        chk("t4_k2", hs_log[2].key, 63);
        chk("t4_state", state, k3);
        hs_log.delete();
        for (int i = 0; i < 8; i++) begin
            keys_next = (i % 2 == 0) ? (k3 | (64'd1 << 5)) : k3;
            wait_frames(1);
        end
        keys_next = k3;
        wait_frames(5);
        chk("t5_state", state, k3);
        chk("t5_events", hs_log.size(), 0);
        rdy_rand = 1'b1;
        for (int i = 0; i < 12; i++) begin
            keys_next = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            wait_frames($urandom_range(1, 5));
        end
        rdy_rand = 1'b0;
        rdy_val = 1'b1;
        keys_next = '0;
        wait_frames(10);
        chk("rand_state", state, 0);
        at_edge();
        rdy_val = 1'b0;
        keys_next = 64'hE0;
        wait_valid();
        hs_log.delete();
        at_edge();
        E = 1'b0;
        repeat (10) at_edge();
        chk("t6_columns_off", columns, 8'hFF);
        rdy_val = 1'b1;
        at_edge();
        rdy_val = 1'b0;
        repeat (3) at_edge();
        chk("t6_drain_count", hs_log.size(), 1);
        chk("t6_drain_key", hs_log[0].key, 5);
        chk("t6_still_valid", ev_valid, 1);
        mon_on = 1'b0;
        #2;
        RESET = 1'b1;
        #1;
        chk("t6_rst_state", state, 0);
        chk("t6_rst_valid", ev_valid, 0);
        chk("t6_rst_columns", columns, 8'hFF);
        at_edge();
        RESET = 1'b0;
        mstate = '0;
        mprev = '0;
        mmatch = 0;
        ecnt = 0;
        pend.delete();
        keys_q = '0;
        keys_next = '0;
        E = 1'b1;
        mon_on = 1'b1;
        wait_frames(3);
        chk("t6_after_state", state, 0);
        chk("t6_after_valid", ev_valid, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/matrix_8x8_scan.md
# matrix_8x8_scan

Scanner for an 8x8 switch/key matrix. It is the input-side counterpart of the 8x8 LED matrix driver: it drives one column at a time, samples the row lines, and debounces whole frames. It keeps a 64-bit pressed-key map and reports each key change as a press/release event over a valid/ready handshake. It sits between the board matrix pins and any consumer, for example the LFSR/display logic or an MCS-51 bus bridge.

## Interface
Parameters:
- SCAN_DIV, 16: CLK cycles each column is driven; must be ≥ 4.
- SETTLE, 8: cycle offset within a column step at which rows are sampled; 1 ≤ SETTLE < SCAN_DIV.
- DEBOUNCE, 4: consecutive identical raw frames required before a frame is accepted; 1 ≤ DEBOUNCE ≤ 15.

Ports:
- CLK, input, 1: single clock.
- RESET, input, 1: asynchronous, active-high reset.
- E, input, 1: scan enable.
- rows, input, 8: row lines, active-low (pulled up; a pressed key pulls its row low when its column is driven).
- columns, output, 8: column drive, active-low; exactly one bit low while scanning.
- state, output, 64: debounced key map; bit col*8+row set = pressed.
- frame_done, output, 1: one-cycle pulse when a raw frame completes.
- ev_valid, output, 1: an event is presented.
- ev_ready, input, 1: the consumer accepts the event.
- ev_key, output, 6: key index {col[2:0], row[2:0]}.
- ev_press, output, 1: 1 = press, 0 = release.

## Operation
- Step counter counts 0..SCAN_DIV-1 and the column index counts 0..7.
  - During column k: columns = ~(8'b1 << k).
  - At step count SETTLE: raw[k*8 + r] <= ~rows_s[r], where rows_s is the (synchronized) row input.
- After the column 7 sample:
  - frame_done pulses.
  - The raw frame is compared with the previous raw frame. Equal: match counter increments (saturating at DEBOUNCE). Different: match counter becomes 1.
- Acceptance:
  - Condition: match counter == DEBOUNCE, raw ≠ state, and the event FSM is in IDLE.
  - Action: state <= raw; diff <= raw ^ old state.
  - If the FSM is not IDLE, acceptance is deferred to a later frame. The counter stays saturated, so the next matching frame accepts.
- Event FSM:
  - IDLE → PRESENT on acceptance.
  - In PRESENT, the lowest set bit i of diff is shown: ev_key = i, ev_press = state[i].
  - On ev_valid & ev_ready, bit i of diff is cleared. The next-lowest bit is presented the next cycle.
  - When diff becomes 0, the FSM returns to IDLE.
- E low:
  - columns = 8'hFF; step, column and match counters are cleared; the partial raw frame is discarded.
  - state is held; pending events continue to drain.
- Simultaneous events: an acceptance and a final handshake in the same cycle do not both apply. The acceptance waits one frame, because the FSM is not IDLE in that cycle.

## Timing
- Reset values:
  - columns 8'hFF (first drive, column 0 low, on the first enabled cycle).
  - state 0, frame_done 0, ev_valid 0, ev_key 0, ev_press 0.
  - All counters 0, FSM IDLE.
- Frame period is 8*SCAN_DIV cycles.
- Row sampling happens SETTLE cycles after the column drive changes, plus the synchronizer depth.
- state and ev_valid update on the same edge, one cycle after the frame_done pulse of the accepting frame.
- All outputs are registered.
- ev_key and ev_press are stable while ev_valid is high and ev_ready is low.
- Throughput is one event per cycle with ev_ready held high.
- RESET mid-event drops all pending events.

## Configuration
- MATRIX_SCAN_SYNC_EN defined: rows pass through a two-flop synchronizer before sampling. Effective sample point is SETTLE+2 cycles after the column change.
- Not defined: rows are used combinationally at the sample cycle. This is for already-synchronous bench stimulus.
- Frame and event timing relative to frame_done are otherwise identical.

## Test plan
All tests use SCAN_DIV=4, SETTLE=2, DEBOUNCE=3, with the sync macro both defined and undefined.
1. Reset, E=1, no keys → columns cycles FE, FD, FB, … 7F every 4 cycles; frame_done pulses every 32 cycles; state stays 0; ev_valid never asserts.
2. Hold key col 2/row 5 → after the 3rd identical frame: state = 1<<21; one event with ev_key=21, ev_press=1. After release and 3 frames: state = 0; one event with ev_key=21, ev_press=0.
3. Press keys 0, 9 and 63 together, ev_ready=1 → events with keys 0, 9, 63 on three consecutive cycles; ev_valid then drops.
4. Same as test 3 with ev_ready=0 for 100 cycles → ev_key held at 0; no new acceptance while pending, even if key 9 bounces; draining resumes when ev_ready rises.
5. Key toggling every frame (bounce) → match counter never reaches 3; state is unchanged; no events.
6. Deassert E mid-frame, then assert RESET during PRESENT → columns = FF while E is low; after RESET, ev_valid=0 and state=0 immediately (asynchronous).
